// File: rtl/cpu_run_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : cpu_run_ctrl_if
// Purpose  : Command, retire-trace and status bundle shared between a host
//            (bench or top level) and the cpu_run_ctrl sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface cpu_run_ctrl_if #(
  parameter int XLEN   = 32,
  parameter int CNT_W  = 32,
  parameter int NUM_BP = 2
);
  // Host commands (single-cycle pulses) and step size
  logic                   cmd_run;
  logic                   cmd_step;
  logic                   cmd_stop;
  logic                   cmd_clear;
  logic [CNT_W-1:0]       step_count;

  // Retire trace from the CPU
  logic                   retire_valid;
  logic [XLEN-1:0]        pc;
  logic [XLEN-1:0]        instr;

  // Breakpoint configuration
  logic [NUM_BP*XLEN-1:0] bp_addr;
  logic [NUM_BP-1:0]      bp_en;

  // Controller status and CPU enable
  logic                   cpu_start;
  logic                   busy;
  logic                   done;
  logic [2:0]             done_cause;
  logic [CNT_W-1:0]       cycle_count;
  logic [CNT_W-1:0]       retire_count;

  // Host / CPU side: drives commands, trace and breakpoint setup
  modport master (
    output cmd_run, cmd_step, cmd_stop, cmd_clear, step_count,
    output retire_valid, pc, instr, bp_addr, bp_en,
    input  cpu_start, busy, done, done_cause, cycle_count, retire_count
  );

  // Controller side
  modport slave (
    input  cmd_run, cmd_step, cmd_stop, cmd_clear, step_count,
    input  retire_valid, pc, instr, bp_addr, bp_en,
    output cpu_start, busy, done, done_cause, cycle_count, retire_count
  );
endinterface
`default_nettype wire

// File: rtl/cpu_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cpu_run_ctrl
// Purpose  : Run/halt sequencer for a single-cycle CPU. Supports free-run,
//            N-instruction step, ecall halt, PC breakpoints and a cycle
//            timeout; keeps cycle/retire counters and reports stop cause.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_run_ctrl #(
  parameter int              XLEN       = 32,
  parameter int              CNT_W      = 32,
  parameter int              NUM_BP     = 2,
  parameter int              MAX_CYCLES = 300,
  parameter logic [XLEN-1:0] HALT_INSTR = 32'h00000073
) (
  input  wire              clk,
  input  wire              rst_n,
  cpu_run_ctrl_if.slave    bus
);

  // Stop-cause encodings reported on done_cause
  localparam logic [2:0] c_cause_none    = 3'd0;
  localparam logic [2:0] c_cause_stop    = 3'd1;
  localparam logic [2:0] c_cause_halt    = 3'd2;
  localparam logic [2:0] c_cause_break   = 3'd3;
  localparam logic [2:0] c_cause_timeout = 3'd4;
  localparam logic [2:0] c_cause_step    = 3'd5;

  // Timeout fires on the enabled cycle whose pre-increment count is
  // MAX_CYCLES-1, i.e. the MAX_CYCLES-th enabled cycle. An equality test
  // means a resume past the limit never re-fires.
  localparam bit               c_timeout_en   = (MAX_CYCLES != 0);
  localparam logic [CNT_W-1:0] c_timeout_last = CNT_W'(MAX_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_cnt_one      = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_STEP   = 2'd2,
    S_HALTED = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       cause_q, cause_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] ret_q, ret_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             cpu_start_q;
  logic             busy_q;
  logic             done_q;

  logic [NUM_BP-1:0] w_bp_hit;
  logic              w_halt_hit;
  logic              w_break_hit;
  logic              w_timeout_hit;
  logic              w_step_hit;
  logic [2:0]        w_stop_cause;
  logic              w_step_ok;
  logic              w_active_d;

  // One address comparator per breakpoint slot
  generate
    for (genvar k = 0; k < NUM_BP; k++) begin : g_bp
      assign w_bp_hit[k] = bus.bp_en[k] && (bus.pc == bus.bp_addr[k*XLEN +: XLEN]);
    end
  endgenerate

  assign w_halt_hit    = bus.retire_valid && (bus.instr == HALT_INSTR);
  assign w_break_hit   = bus.retire_valid && (|w_bp_hit);
  assign w_timeout_hit = c_timeout_en && (cyc_q == c_timeout_last);
  assign w_step_hit    = (state_q == S_STEP) && bus.retire_valid && (rem_q == c_cnt_one);
  assign w_step_ok     = bus.cmd_step && (bus.step_count != '0);

  // Highest-priority stop condition for the current active cycle
  always_comb begin
    w_stop_cause = c_cause_none;
    if (bus.cmd_stop)        w_stop_cause = c_cause_stop;
    else if (w_halt_hit)     w_stop_cause = c_cause_halt;
    else if (w_break_hit)    w_stop_cause = c_cause_break;
    else if (w_timeout_hit)  w_stop_cause = c_cause_timeout;
    else if (w_step_hit)     w_stop_cause = c_cause_step;
  end

  // Next-state, counter and cause logic
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    cyc_d   = cyc_q;
    ret_d   = ret_q;
    rem_d   = rem_q;

    if (bus.cmd_clear) begin
      state_d = S_IDLE;
      cause_d = c_cause_none;
      cyc_d   = '0;
      ret_d   = '0;
      rem_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE, S_HALTED: begin
          // cmd_stop outranks run/step but has nothing to stop here
          if (bus.cmd_stop) begin
            state_d = state_q;
          end else if (bus.cmd_run) begin
            state_d = S_RUN;
            cause_d = c_cause_none;
          end else if (w_step_ok) begin
            state_d = S_STEP;
            cause_d = c_cause_none;
            rem_d   = bus.step_count;
          end
        end

        S_RUN, S_STEP: begin
          // Enabled cycle: count it, and the retire if any, saturating
          if (cyc_q != '1) cyc_d = cyc_q + c_cnt_one;
          if (bus.retire_valid && (ret_q != '1)) ret_d = ret_q + c_cnt_one;
          if ((state_q == S_STEP) && bus.retire_valid && (rem_q != '0))
            rem_d = rem_q - c_cnt_one;

          if (w_stop_cause != c_cause_none) begin
            state_d = S_HALTED;
            cause_d = w_stop_cause;
          end else if (bus.cmd_run) begin
            // Switching to free-run drops any step limit
            state_d = S_RUN;
            rem_d   = '0;
          end
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

  assign w_active_d = (state_d == S_RUN) || (state_d == S_STEP);

  // State, counters and registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cause_q     <= c_cause_none;
      cyc_q       <= '0;
      ret_q       <= '0;
      rem_q       <= '0;
      cpu_start_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cause_q     <= cause_d;
      cyc_q       <= cyc_d;
      ret_q       <= ret_d;
      rem_q       <= rem_d;
      cpu_start_q <= w_active_d;
      busy_q      <= w_active_d;
      done_q      <= (state_d == S_HALTED);
    end
  end

  assign bus.cpu_start    = cpu_start_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.done_cause   = cause_q;
  assign bus.cycle_count  = cyc_q;
  assign bus.retire_count = ret_q;

endmodule
`default_nettype wire

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
Parametrised run/halt controller placed between the bench or top level and the single-cycle CPU. It generalises the fixed "assert start, run for a fixed time" bring-up sequence into a commanded sequencer. Supported operations are free-run, N-instruction step, ecall halt detection, PC breakpoints and a cycle timeout. It drives the CPU's start/enable input, keeps cycle and retire counters, and reports why execution stopped.

Parameters:
XLEN, 32, width of pc, instr and breakpoint addresses
CNT_W, 32, width of cycle_count, retire_count and step_count
NUM_BP, 2, number of PC breakpoint comparators
MAX_CYCLES, 300, timeout in enabled cycles; 0 disables timeout
HALT_INSTR, 32'h00000073, instruction encoding that halts on retire (ecall)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
cmd_run  in  1  pulse: free-run from IDLE or HALTED
cmd_step  in  1  pulse: run step_count instructions
cmd_stop  in  1  pulse: force halt
cmd_clear  in  1  pulse: clear counters and cause, return to IDLE
step_count  in  CNT_W  instructions to execute on cmd_step
retire_valid  in  1  CPU retired an instruction this cycle
pc  in  XLEN  PC of the retiring instruction
instr  in  XLEN  encoding of the retiring instruction
bp_addr  in  NUM_BP*XLEN  breakpoint addresses; slot k = bits [k*XLEN +: XLEN]
bp_en  in  NUM_BP  per-slot breakpoint enable
cpu_start  out  1  CPU run enable (start)
busy  out  1  high in RUN or STEP
done  out  1  high in HALTED
done_cause  out  3  0 NONE, 1 STOP, 2 HALT, 3 BREAK, 4 TIMEOUT, 5 STEP
cycle_count  out  CNT_W  cycles with cpu_start=1
retire_count  out  CNT_W  retire_valid cycles with cpu_start=1

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - cpu_start=0, busy=0, done=0.
  - done_cause=0, both counters=0, internal remaining=0.
- States: IDLE, RUN, STEP, HALTED. All outputs are registered. busy/done/cpu_start change on the edge that changes state.
- Command priority in any state: cmd_clear > cmd_stop > cmd_run > cmd_step.
- cmd_clear from any state:
  - Next state IDLE.
  - Counters, done_cause and remaining are zeroed.
- IDLE:
  - cmd_run -> RUN.
  - cmd_step with step_count!=0 -> STEP, remaining=step_count.
  - cmd_step with step_count=0 is ignored.
  - cmd_stop in IDLE is ignored.
- RUN/STEP, each cycle:
  - cycle_count+1.
  - retire_count+1 if retire_valid.
  - Both counters saturate at all-ones.
- Stop conditions, evaluated the same cycle; priority STOP > HALT > BREAK > TIMEOUT > STEP:
  - STOP: cmd_stop.
  - HALT: retire_valid && instr==HALT_INSTR.
  - BREAK: retire_valid && any k with bp_en[k] && pc==bp_addr[k].
  - TIMEOUT: MAX_CYCLES!=0 && cycle_count==MAX_CYCLES-1 (the MAX_CYCLES-th enabled cycle).
  - STEP: STEP state && retire_valid && remaining==1.
- On any stop condition:
  - Next state HALTED; cpu_start falls on that edge.
  - done_cause latches the highest-priority cause.
  - The retiring instruction in that cycle is counted.
- STEP state: remaining decrements on each retire_valid.
- HALTED:
  - cpu_start=0 and counters hold.
  - cmd_run or cmd_step (step_count!=0) resumes to RUN/STEP. Counters are kept; done_cause is set to 0 on that edge.
  - A breakpoint at the halted PC does not re-fire, because matching is on the next retire.
- Timeout when resuming from HALTED:
  - TIMEOUT fires only while cycle_count<MAX_CYCLES.
  - Once cycle_count>=MAX_CYCLES, a resume runs until another cause occurs.
- cmd_run while already in RUN or STEP: switches to RUN (step limit dropped). cmd_step while in RUN or STEP is ignored.
- retire_valid in IDLE or HALTED is ignored; no counting, no cause.
- Mid-operation reset: returns to the reset values immediately (async). The first edge after release is an IDLE cycle.

Test Plan:
- Reset, then cmd_run at edge 2, no retires, MAX_CYCLES=300 -> cpu_start=1 from edge 3; after 300 enabled cycles done=1, done_cause=4, cycle_count=300, cpu_start=0.
- cmd_run; on the 7th retire drive instr=32'h00000073 -> done_cause=2, retire_count=7, cpu_start falls on the next edge.
- bp_addr slot1=32'h0000_0010, bp_en=2'b10, run with retire every cycle, PC +4 from 0 -> halt with done_cause=3 at pc=0x10, retire_count=5. Then cmd_run resumes with no re-trigger at 0x10 and counters continue from 5.
- cmd_step step_count=3, retire_valid asserted every other cycle -> done_cause=5 after the 3rd retire, retire_count=3, cycle_count=5. cmd_step with step_count=0 in IDLE -> stays IDLE.
- Same cycle: cmd_stop + HALT_INSTR retire + breakpoint match -> done_cause=1. cmd_clear+cmd_run together in HALTED -> IDLE, counters=0.
- Drop rst_n mid-RUN for 3 ns off-edge -> cpu_start=0, counters=0 immediately. After release, cmd_run restarts cleanly at cycle_count=0.
